// File: rtl/trig_pkg.sv
// Shared types and elaboration helpers for the multi-channel trigger generator.
// Optional per-channel pulse counting is enabled with the TRIG_COUNT_EN macro.
package trig_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = 2'd0,
        DELAY   = 2'd1,
        PULSE   = 2'd2,
        HOLDOFF = 2'd3
    } trig_state_e;

    function automatic int unsigned us_to_cyc(input int unsigned t_us, input int unsigned clk_mhz);
        return t_us * clk_mhz;
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b, input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Bits needed to hold values 0..max_val (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/trig_channel.sv
// One trigger channel: ready synchroniser, DELAY/PULSE/HOLDOFF sequencer, shared down-counter.
// With TRIG_COUNT_EN defined, also keeps a wrapping count of pulses issued.
module trig_channel
    import trig_pkg::*;
#(
    parameter int unsigned DLY   = 12,
    parameter int unsigned PLS   = 24,
    parameter int unsigned HLD   = 96
`ifdef TRIG_COUNT_EN
    ,
    parameter int unsigned CNT_W = 16
`endif
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             ch_en,
    input  logic             bin_rdy_n,
    input  logic             det_rdy_n,
    output logic             trig_n,
    output logic             busy
`ifdef TRIG_COUNT_EN
    ,
    output logic [CNT_W-1:0] trig_count
`endif
);

    localparam int unsigned TMR_W = cnt_width(max3(DLY, PLS, HLD));
    localparam logic [TMR_W-1:0] DLY_LD = (DLY > 0) ? TMR_W'(DLY - 1) : '0;
    localparam logic [TMR_W-1:0] PLS_LD = TMR_W'(PLS - 1);
    localparam logic [TMR_W-1:0] HLD_LD = TMR_W'(HLD - 1);

    // Synchronisers carry the active-high sense so their reset value means "not ready".
    logic [1:0] bin_sync;
    logic [1:0] det_sync;
    logic       rdy;

    trig_state_e      state;
    trig_state_e      state_nxt;
    logic [TMR_W-1:0] tmr;
    logic [TMR_W-1:0] tmr_nxt;
    logic             tmr_zero;

    assign rdy      = ch_en & bin_sync[1] & det_sync[1];
    assign tmr_zero = (tmr == '0);

    // Next-state and counter reload logic.
    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr;
        case (state)
            IDLE: begin
                if (rdy) begin
                    if (DLY > 0) begin
                        state_nxt = DELAY;
                        tmr_nxt   = DLY_LD;
                    end else begin
                        state_nxt = PULSE;
                        tmr_nxt   = PLS_LD;
                    end
                end
            end
            DELAY: begin
                if (!rdy) begin
                    state_nxt = IDLE;
                    tmr_nxt   = '0;
                end else if (tmr_zero) begin
                    state_nxt = PULSE;
                    tmr_nxt   = PLS_LD;
                end else begin
                    tmr_nxt = tmr - TMR_W'(1);
                end
            end
            PULSE: begin
                if (tmr_zero) begin
                    state_nxt = HOLDOFF;
                    tmr_nxt   = HLD_LD;
                end else begin
                    tmr_nxt = tmr - TMR_W'(1);
                end
            end
            HOLDOFF: begin
                if (tmr_zero) begin
                    state_nxt = IDLE;
                end else begin
                    tmr_nxt = tmr - TMR_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                tmr_nxt   = '0;
            end
        endcase
    end

    // State, counter, synchronisers and registered outputs.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state    <= IDLE;
            tmr      <= '0;
            bin_sync <= '0;
            det_sync <= '0;
            trig_n   <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            tmr      <= tmr_nxt;
            bin_sync <= {bin_sync[0], ~bin_rdy_n};
            det_sync <= {det_sync[0], ~det_rdy_n};
            trig_n   <= (state_nxt != PULSE);
            busy     <= (state_nxt != IDLE);
        end
    end

`ifdef TRIG_COUNT_EN
    // Counts PULSE entries; wraps naturally at 2^CNT_W.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            trig_count <= '0;
        end else if ((state != PULSE) && (state_nxt == PULSE)) begin
            trig_count <= trig_count + CNT_W'(1);
        end
    end
`endif

endmodule

// File: rtl/multi_trigger_gen.sv
// N-channel delayed trigger-pulse generator built from independent trig_channel instances.
// Define TRIG_COUNT_EN to add the packed per-channel trig_count output.
module multi_trigger_gen
    import trig_pkg::*;
#(
    parameter int unsigned N_CH       = 2,
    parameter int unsigned CLK_MHZ    = 12,
    parameter int unsigned T_US_DELAY = 10,
    parameter int unsigned T_US_PULSE = 50,
    parameter int unsigned T_US_INT   = 25000,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    input  logic [N_CH-1:0]         ch_en,
    input  logic [N_CH-1:0]         bin_rdy_n,
    input  logic [N_CH-1:0]         det_rdy_n,
    output logic [N_CH-1:0]         trig_n,
    output logic [N_CH-1:0]         busy
`ifdef TRIG_COUNT_EN
    ,
    output logic [N_CH*CNT_W-1:0]   trig_count
`endif
);

    localparam int unsigned DLY = us_to_cyc(T_US_DELAY, CLK_MHZ);
    localparam int unsigned PLS = us_to_cyc(T_US_PULSE, CLK_MHZ);
    localparam int unsigned HLD = us_to_cyc(T_US_INT - T_US_PULSE, CLK_MHZ);

    // Reject parameter sets the channel sequencer cannot honour.
    if ((N_CH < 1) || (N_CH > 8)) begin : g_bad_nch
        $error("multi_trigger_gen: N_CH must be 1..8");
    end
    if (T_US_PULSE < 1) begin : g_bad_pulse
        $error("multi_trigger_gen: T_US_PULSE must be >= 1");
    end
    if (T_US_INT <= T_US_PULSE) begin : g_bad_int
        $error("multi_trigger_gen: T_US_INT must exceed T_US_PULSE");
    end
    if (CNT_W < 1) begin : g_bad_cntw
        $error("multi_trigger_gen: CNT_W must be >= 1");
    end

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        trig_channel #(
            .DLY   (DLY),
            .PLS   (PLS),
            .HLD   (HLD)
`ifdef TRIG_COUNT_EN
            ,
            .CNT_W (CNT_W)
`endif
        ) u_ch (
            .sys_clk    (sys_clk),
            .sys_rst    (sys_rst),
            .ch_en      (ch_en[ch]),
            .bin_rdy_n  (bin_rdy_n[ch]),
            .det_rdy_n  (det_rdy_n[ch]),
            .trig_n     (trig_n[ch]),
            .busy       (busy[ch])
`ifdef TRIG_COUNT_EN
            ,
            .trig_count (trig_count[ch*CNT_W +: CNT_W])
`endif
        );
    end

endmodule

// File: tb/tb_multi_trigger_gen.sv
// Scoreboard bench for multi_trigger_gen: expected trig_n/busy edges are queued by stimulus
// and matched by an independent monitor. TRIG_COUNT_EN adds trig_count checks.
module tb_multi_trigger_gen;

    localparam int unsigned N_CH  = 4;
    localparam int unsigned CNT_W = 3;
    // Expected timing for this configuration: DLY=12, PLS=24, HLD=96 cycles.
    localparam int T_FALL = 14;
    localparam int T_RISE = 38;
    localparam int T_IDLE = 134;
    localparam int T_REPEAT = 133;

    localparam int K_FALL  = 0;
    localparam int K_RISE  = 1;
    localparam int K_BUSYF = 2;

    logic              sys_clk = 1'b0;
    logic              sys_rst;
    logic [N_CH-1:0]   ch_en;
    logic [N_CH-1:0]   bin_rdy_n;
    logic [N_CH-1:0]   det_rdy_n;
    logic [N_CH-1:0]   trig_n;
    logic [N_CH-1:0]   busy;
`ifdef TRIG_COUNT_EN
    logic [N_CH*CNT_W-1:0] trig_count;
`endif

    multi_trigger_gen #(
        .N_CH       (N_CH),
        .CLK_MHZ    (12),
        .T_US_DELAY (1),
        .T_US_PULSE (2),
        .T_US_INT   (10),
        .CNT_W      (CNT_W)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .ch_en      (ch_en),
        .bin_rdy_n  (bin_rdy_n),
        .det_rdy_n  (det_rdy_n),
        .trig_n     (trig_n),
        .busy       (busy)
`ifdef TRIG_COUNT_EN
        ,
        .trig_count (trig_count)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    typedef struct {
        int kind;
        int ch;
        int cyc;
    } exp_t;

    exp_t            exp_q[$];
    int              total = 0;
    int              bad   = 0;
    bit              mon_en = 1'b0;
    logic [N_CH-1:0] trig_prev;
    logic [N_CH-1:0] busy_prev;

    function automatic string kname(input int kind);
        case (kind)
            K_FALL:  return "trig_fall";
            K_RISE:  return "trig_rise";
            default: return "busy_fall";
        endcase
    endfunction

    task automatic push_evt(input int kind, input int ch, input int c);
        exp_t e;
        e.kind = kind;
        e.ch   = ch;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    // Full pulse qualified at edge k: fall, rise, return to IDLE.
    task automatic expect_pulse(input int ch, input int k);
        push_evt(K_FALL, ch, k + T_FALL);
        push_evt(K_RISE, ch, k + T_RISE);
        push_evt(K_BUSYF, ch, k + T_IDLE);
    endtask

    task automatic check_evt(input int kind, input int ch);
        int idx;
        idx = -1;
        for (int j = 0; j < exp_q.size(); j++) begin
            if (idx < 0 && exp_q[j].kind == kind && exp_q[j].ch == ch) idx = j;
        end
        total++;
        if (idx < 0) begin
            bad++;
            $display("FAIL unexpected %s ch%0d at edge %0d: got an edge, required none", kname(kind), ch, cyc);
        end else begin
            if (exp_q[idx].cyc != cyc) begin
                bad++;
                $display("FAIL %s ch%0d: got edge %0d, required edge %0d", kname(kind), ch, cyc, exp_q[idx].cyc);
            end
            exp_q.delete(idx);
        end
    endtask

    always @(negedge sys_clk) begin
        if (mon_en) begin
            for (int i = 0; i < N_CH; i++) begin
                if (trig_n[i] !== trig_prev[i]) check_evt(trig_n[i] ? K_RISE : K_FALL, i);
                if (busy_prev[i] === 1'b1 && busy[i] === 1'b0) check_evt(K_BUSYF, i);
            end
            trig_prev = trig_n;
            busy_prev = busy;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Return #1 after the posedge that brings the edge counter to t.
    task automatic at(input int t);
        while (cyc < t) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    int b;
    int k;
    int k2;
    int r;

    initial begin
        sys_rst   = 1'b1;
        ch_en     = '1;
        bin_rdy_n = '1;
        det_rdy_n = '1;

        at(3);
        chk("reset_trig_n", 32'(trig_n), 32'hF);
        chk("reset_busy", 32'(busy), 32'h0);
`ifdef TRIG_COUNT_EN
        chk("reset_count", 32'(trig_count), 32'h0);
`endif
        sys_rst = 1'b0;
        at(6);
        chk("idle_trig_n", 32'(trig_n), 32'hF);
        chk("idle_busy", 32'(busy), 32'h0);
        trig_prev = trig_n;
        busy_prev = busy;
        mon_en = 1'b1;

        // Ready held on ch0: two pulses, second after holdoff, one IDLE cycle and a fresh delay.
        b = 10;
        at(b);
        bin_rdy_n[0] = 1'b0;
        det_rdy_n[0] = 1'b0;
        k = b + 1;
        expect_pulse(0, k);
        expect_pulse(0, k + T_REPEAT);
        at(k + 5);
        chk("t1_busy_in_delay", 32'(busy), 32'h1);
        at(k + 160);
        bin_rdy_n[0] = 1'b1;
        det_rdy_n[0] = 1'b1;
        at(k + 280);

        // Ready drops during DELAY: abort without pulse, then re-arm.
        b = 300;
        at(b);
        bin_rdy_n[0] = 1'b0;
        det_rdy_n[0] = 1'b0;
        k = b + 1;
        push_evt(K_BUSYF, 0, k + 9);
        at(k + 6);
        det_rdy_n[0] = 1'b1;
        at(k + 12);
        chk("t2_no_pulse", 32'(trig_n), 32'hF);
        at(k + 20);
        det_rdy_n[0] = 1'b0;
        k2 = k + 21;
        expect_pulse(0, k2);
        at(k2 + 50);
        bin_rdy_n[0] = 1'b1;
        det_rdy_n[0] = 1'b1;
        at(k2 + 140);

        // ch_en dropped mid-pulse: full pulse and holdoff, no retrigger.
        b = 470;
        at(b);
        bin_rdy_n[0] = 1'b0;
        det_rdy_n[0] = 1'b0;
        k = b + 1;
        expect_pulse(0, k);
        at(k + 24);
        ch_en[0] = 1'b0;
        at(k + 200);
        chk("t3_no_retrigger_busy", 32'(busy), 32'h0);
        bin_rdy_n[0] = 1'b1;
        det_rdy_n[0] = 1'b1;
        at(k + 205);
        ch_en[0] = 1'b1;
        at(k + 219);

        // Reset mid-pulse, inputs still low: pulse cut, new pulse 14 cycles after release.
        b = 700;
        at(b);
        bin_rdy_n[0] = 1'b0;
        det_rdy_n[0] = 1'b0;
        k = b + 1;
        push_evt(K_FALL, 0, k + T_FALL);
        push_evt(K_RISE, 0, k + 22);
        push_evt(K_BUSYF, 0, k + 22);
        at(k + 21);
        sys_rst = 1'b1;
        at(k + 23);
        chk("t4_reset_trig_n", 32'(trig_n), 32'hF);
        chk("t4_reset_busy", 32'(busy), 32'h0);
        at(k + 25);
        sys_rst = 1'b0;
        r = k + 26;
        expect_pulse(0, r);
        at(r + 50);
        bin_rdy_n[0] = 1'b1;
        det_rdy_n[0] = 1'b1;
        at(r + 143);

        // All four channels, staggered qualification 3 cycles apart.
        b = 880;
        at(b);
        bin_rdy_n = '0;
        for (int i = 0; i < N_CH; i++) begin
            at(b + 3 * i);
            det_rdy_n[i] = 1'b0;
            expect_pulse(i, b + 3 * i + 1);
        end
        at(b + 20);
        chk("t5_all_busy", 32'(busy), 32'hF);
        at(b + 60);
        bin_rdy_n = '1;
        det_rdy_n = '1;
        at(b + 150);
`ifdef TRIG_COUNT_EN
        chk("t5_counts", 32'(trig_count), 32'h24A);
`endif

        // Clean reset, then 9 back-to-back pulses on ch0 (count wraps at 8).
        at(1040);
        sys_rst = 1'b1;
        at(1043);
        sys_rst = 1'b0;
        b = 1050;
        at(b);
        bin_rdy_n[0] = 1'b0;
        det_rdy_n[0] = 1'b0;
        k = b + 1;
        for (int j = 0; j < 9; j++) expect_pulse(0, k + j * T_REPEAT);
        at(k + 1090);
        bin_rdy_n[0] = 1'b1;
        det_rdy_n[0] = 1'b1;
        at(k + 1210);
        chk("t6_final_busy", 32'(busy), 32'h0);
`ifdef TRIG_COUNT_EN
        chk("t6_count_wrap", 32'(trig_count), 32'h001);
`endif

        mon_en = 1'b0;
        while (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL missing %s ch%0d: got no edge, required edge %0d",
                     kname(exp_q[0].kind), exp_q[0].ch, exp_q[0].cyc);
            void'(exp_q.pop_front());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
